// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter, the four
// requesting sources and the consumer of the 4:1 mux output.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] switch;
    logic [3:0] grant;
    logic       out_valid;
    logic [3:0] ack;

    modport master (
        input  req,
        input  out_ready,
        output switch,
        output grant,
        output out_valid,
        output ack
    );

    modport slave (
        output req,
        output out_ready,
        input  switch,
        input  grant,
        input  out_valid,
        input  ack
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select, with optional
// multi-beat bursts per grant and a valid/ready output handshake.
module mux4_rr_arbiter #(
    parameter int unsigned BURST = 1
) (
    input  logic              clk,
    input  logic              rst,
    mux4_rr_arbiter_if.master bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [7:0] BEAT_MAX = 8'(BURST - 1);

    state_e     state_q, state_d;
    logic [1:0] switch_q, switch_d;
    logic [1:0] last_q, last_d;
    logic [3:0] grant_q, grant_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] beats_q, beats_d;

    logic       xfer;
    logic [3:0] arb_req;
    logic [1:0] arb_base;
    logic [1:0] cand;
    logic       win_found;
    logic [1:0] win_idx;

    assign xfer = out_valid_q & bus.out_ready;

    // The source being served is masked so it cannot win its own
    // rotation; it only comes back through IDLE.
    assign arb_base = (state_q == IDLE) ? last_q : switch_q;
    assign arb_req  = (state_q == IDLE) ? bus.req
                                        : (bus.req & ~grant_q);

    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = arb_base + 2'(k);
            if (!win_found && arb_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        switch_d    = switch_q;
        last_d      = last_q;
        grant_d     = grant_q;
        out_valid_d = out_valid_q;
        beats_d     = beats_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = GRANT;
                    switch_d    = win_idx;
                    grant_d     = 4'b0001 << win_idx;
                    beats_d     = 8'd0;
                    out_valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (xfer) begin
                    // Burst continuation beats rotation.
                    if (beats_q != BEAT_MAX && bus.req[switch_q]) begin
                        beats_d = beats_q + 8'd1;
                    end else begin
                        last_d = switch_q;
                        if (win_found) begin
                            switch_d = win_idx;
                            grant_d  = 4'b0001 << win_idx;
                            beats_d  = 8'd0;
                        end else begin
                            state_d     = IDLE;
                            grant_d     = 4'b0000;
                            out_valid_d = 1'b0;
                            beats_d     = 8'd0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            switch_q    <= 2'd0;
            last_q      <= 2'd3;
            grant_q     <= 4'b0000;
            out_valid_q <= 1'b0;
            beats_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            switch_q    <= switch_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            beats_q     <= beats_d;
        end
    end

    assign bus.switch    = switch_q;
    assign bus.grant     = grant_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ack       = grant_q & {4{xfer}};

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: directed stimulus queues expected results, a
// negedge monitor pops and compares them against two arbiter instances.
module tb_mux4_rr_arbiter;

    logic clk;
    logic rst;

    mux4_rr_arbiter_if b1();
    mux4_rr_arbiter_if b3();

    mux4_rr_arbiter #(.BURST(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.master)
    );

    mux4_rr_arbiter #(.BURST(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.master)
    );

    typedef struct {
        logic       v;
        int         s;
        logic [3:0] g;
        logic [3:0] a;
    } cyc_t;

    cyc_t  cq[$];
    string nq[$];
    int    q1[$];
    int    q3[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    done  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected dut1 outputs at this cycle's falling edge; s < 0 skips switch.
    task automatic exp_c(input logic v, input int s, input logic [3:0] g,
                         input logic [3:0] a, input string n);
        cyc_t e;
        e.v = v;
        e.s = s;
        e.g = g;
        e.a = a;
        cq.push_back(e);
        nq.push_back(n);
    endtask

    always @(negedge clk) begin
        cyc_t       e;
        string      n;
        int         s;
        logic [3:0] oh;
        if (cq.size() > 0) begin
            e = cq.pop_front();
            n = nq.pop_front();
            chk({n, ".valid"}, 32'(b1.out_valid), 32'(e.v));
            chk({n, ".grant"}, 32'(b1.grant), 32'(e.g));
            chk({n, ".ack"}, 32'(b1.ack), 32'(e.a));
            if (e.s >= 0) chk({n, ".switch"}, 32'(b1.switch), e.s);
        end
        if (!rst && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
                chk("b1.unexpected_xfer", 32'(b1.switch), 32'hdead);
            end else begin
                s  = q1.pop_front();
                oh = 4'b0001 << s[1:0];
                chk("b1.xfer.switch", 32'(b1.switch), s);
                chk("b1.xfer.grant", 32'(b1.grant), 32'(oh));
                chk("b1.xfer.ack", 32'(b1.ack), 32'(oh));
            end
        end
        if (!rst && b3.out_valid && b3.out_ready) begin
            if (q3.size() == 0) begin
                chk("b3.unexpected_xfer", 32'(b3.switch), 32'hdead);
            end else begin
                s  = q3.pop_front();
                oh = 4'b0001 << s[1:0];
                chk("b3.xfer.switch", 32'(b3.switch), s);
                chk("b3.xfer.grant", 32'(b3.grant), 32'(oh));
                chk("b3.xfer.ack", 32'(b3.ack), 32'(oh));
            end
        end
        if (done) begin
            chk("b1.pending_xfers", 32'(q1.size()), 32'd0);
            chk("b3.pending_xfers", 32'(q3.size()), 32'd0);
            chk("pending_cycle_checks", 32'(cq.size()), 32'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                     n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        b1.req       = 4'b0000;
        b1.out_ready = 1'b0;
        b3.req       = 4'b0000;
        b3.out_ready = 1'b0;

        // Reset and idle
        step();
        step();
        exp_c(1'b0, 0, 4'b0000, 4'b0000, "reset");
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_c(1'b0, 0, 4'b0000, 4'b0000, "idle");
            step();
        end
        b1.req = 4'b0001;
        exp_c(1'b0, 0, 4'b0000, 4'b0000, "idle_req");
        step();
        exp_c(1'b1, 0, 4'b0001, 4'b0000, "first_grant");
        step();
        b1.out_ready = 1'b1;
        exp_c(1'b1, 0, 4'b0001, 4'b0001, "first_ack");
        q1.push_back(0);
        step();
        b1.req = 4'b0000;
        exp_c(1'b0, -1, 4'b0000, 4'b0000, "first_done");

        // Fair rotation from a fresh reset
        step();
        rst = 1'b1;
        step();
        rst    = 1'b0;
        b1.req = 4'b1111;
        exp_c(1'b0, 0, 4'b0000, 4'b0000, "rot_idle");
        for (int i = 0; i < 8; i++) q1.push_back(i % 4);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 7) b1.req = 4'b1000;
        end
        step();
        b1.req = 4'b0000;
        exp_c(1'b0, -1, 4'b0000, 4'b0000, "rot_done");

        // Backpressure
        step();
        b1.req       = 4'b0110;
        b1.out_ready = 1'b0;
        exp_c(1'b0, -1, 4'b0000, 4'b0000, "bp_idle");
        for (int i = 0; i < 4; i++) begin
            step();
            exp_c(1'b1, 1, 4'b0010, 4'b0000, "bp_hold");
        end
        step();
        b1.out_ready = 1'b1;
        exp_c(1'b1, 1, 4'b0010, 4'b0010, "bp_ack");
        q1.push_back(1);
        step();
        b1.req = 4'b0100;
        exp_c(1'b1, 2, 4'b0100, 4'b0100, "bp_next");
        q1.push_back(2);
        step();
        b1.req = 4'b0000;
        exp_c(1'b0, -1, 4'b0000, 4'b0000, "bp_done");

        // Lone requester re-enters through IDLE
        step();
        b1.req = 4'b1000;
        exp_c(1'b0, -1, 4'b0000, 4'b0000, "lone_idle");
        step();
        exp_c(1'b1, 3, 4'b1000, 4'b1000, "lone_g1");
        q1.push_back(3);
        step();
        exp_c(1'b0, -1, 4'b0000, 4'b0000, "lone_gap");
        step();
        exp_c(1'b1, 3, 4'b1000, 4'b1000, "lone_g2");
        q1.push_back(3);
        step();
        b1.req = 4'b0000;
        exp_c(1'b0, -1, 4'b0000, 4'b0000, "lone_done");

        // Asynchronous reset in the middle of a grant on source 2
        step();
        b1.req       = 4'b0100;
        b1.out_ready = 1'b0;
        exp_c(1'b0, -1, 4'b0000, 4'b0000, "rm_idle");
        step();
        exp_c(1'b1, 2, 4'b0100, 4'b0000, "rm_grant");
        step();
        b1.out_ready = 1'b1;
        rst          = 1'b1;
        exp_c(1'b0, 0, 4'b0000, 4'b0000, "rm_async");
        step();
        rst    = 1'b0;
        b1.req = 4'b1111;
        exp_c(1'b0, 0, 4'b0000, 4'b0000, "rm_idle2");
        step();
        exp_c(1'b1, 0, 4'b0001, 4'b0001, "rm_first");
        q1.push_back(0);
        step();
        b1.req       = 4'b0000;
        b1.out_ready = 1'b0;
        rst          = 1'b1;
        step();
        rst = 1'b0;

        // Bursts of three, then a source cutting its burst short
        b3.req       = 4'b1001;
        b3.out_ready = 1'b1;
        q3.push_back(0); q3.push_back(0); q3.push_back(0);
        q3.push_back(3); q3.push_back(3); q3.push_back(3);
        q3.push_back(0); q3.push_back(0);
        q3.push_back(3); q3.push_back(3); q3.push_back(3);
        for (int i = 0; i < 11; i++) begin
            step();
            if (i == 7) b3.req = 4'b1000;
        end
        step();
        b3.req = 4'b0000;
        step();
        step();
        done = 1'b1;
    end

endmodule
